ins_mem_writer: RTL and testbench

INS_MEM_WRITER -- requirements
Module: ins_mem_writer

---
 rtl/ins_mem_writer_pkg.sv | 18 +
 rtl/ins_mem_writer_word_serializer.sv | 45 ++++
 rtl/ins_mem_writer.sv | 121 ++++++++++++
 tb/tb_ins_mem_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_mem_writer_pkg.sv
// Shared definitions for the instruction-memory writer: FSM encodings,
// memory geometry and byte-lane width.
package ins_mem_writer_pkg;

  localparam int MEM_BYTES_DEFAULT = 128;
  localparam int ADDR_W            = 7;
  localparam int LANE_W            = 8;
  localparam int WORD_W            = 32;
  localparam int COUNT_W           = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } wr_state_t;

endpackage

// File: rtl/ins_mem_writer_word_serializer.sv
// Holds one captured 32-bit instruction word and presents it one byte at a
// time, most significant byte first, under control of a 2-bit byte index.
module word_serializer
  import ins_mem_writer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              load,
  input  logic              advance,
  input  logic [WORD_W-1:0] word_in,
  output logic [LANE_W-1:0] byte_out,
  output logic [1:0]        byte_idx,
  output logic              last_byte
);

  logic [WORD_W-1:0] word_q;

  // Capture the word on load; step the byte index while writing.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      word_q   <= '0;
      byte_idx <= 2'd0;
    end else if (load) begin
      word_q   <= word_in;
      byte_idx <= 2'd0;
    end else if (advance) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Big-endian lane select.
  always_comb begin
    byte_out = word_q[31:24];
    case (byte_idx)
      2'd0: byte_out = word_q[31:24];
      2'd1: byte_out = word_q[23:16];
      2'd2: byte_out = word_q[15:8];
      2'd3: byte_out = word_q[7:0];
      default: byte_out = word_q[31:24];
    endcase
  end

  assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/ins_mem_writer.sv
// Loads a stream of 32-bit instruction words into a byte-wide instruction
// memory, blocking instruction fetch for the duration of the session.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; fetch allowed
//   ACCEPT | in_ready=1, waiting for an instruction word handshake
//   WRITE  | four byte strobes of the captured word, MSB byte first
//   DONE   | one-cycle done pulse, then back to IDLE
module ins_mem_writer
  import ins_mem_writer_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [LANE_W-1:0]  mem_wdata,
  output logic               InsMemRW,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] word_count,
  output logic               overflow
);

  localparam logic [7:0] MEM_LIM = 8'(MEM_BYTES);

  wr_state_t         state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_adv;
  logic [7:0]        addr_sum;
  logic              last_q;
  logic              handshake;
  logic              byte_end;
  logic [LANE_W-1:0] ser_byte;
  logic [1:0]        byte_idx;

  assign handshake = (state == ST_ACCEPT) && in_valid;
  assign byte_end  = (state == ST_WRITE) && (byte_idx == 2'd3);
  assign addr_sum  = {1'b0, addr} + 8'd4;
  assign addr_adv  = (addr_sum >= MEM_LIM) ? 7'(addr_sum - MEM_LIM) : addr_sum[6:0];

  word_serializer u_ser (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .load      (handshake),
    .advance   (state == ST_WRITE),
    .word_in   (in_data),
    .byte_out  (ser_byte),
    .byte_idx  (byte_idx),
    .last_byte ()
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_ACCEPT;
      ST_ACCEPT: if (in_valid) state_next = ST_WRITE;
      ST_WRITE: begin
        if (byte_idx == 2'd3) begin
          if (last_q || (addr_adv == '0)) state_next = ST_DONE;
          else                            state_next = ST_ACCEPT;
        end
      end
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Session address, word counter, sticky overflow and captured last flag.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      addr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        addr       <= {base_addr[6:2], 2'b00};
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (handshake) last_q <= in_last;
      if (byte_end) begin
        addr       <= addr_adv;
        word_count <= word_count + 6'd1;
        if (!last_q && (addr_adv == '0)) overflow <= 1'b1;
      end
    end
  end

  // Outputs are decoded straight from the state so reset clears them at once.
  always_comb begin
    in_ready  = (state == ST_ACCEPT);
    mem_we    = (state == ST_WRITE);
    busy      = (state != ST_IDLE);
    InsMemRW  = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_WRITE) begin
      mem_addr  = addr + {5'd0, byte_idx};
      mem_wdata = ser_byte;
    end
  end

endmodule

// File: tb/tb_ins_mem_writer.sv
// Directed bench for ins_mem_writer with a queue-based model of the byte
// writes each session must produce.
module tb_ins_mem_writer;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        start;
  logic [6:0]  base_addr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        InsMemRW;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  int done_exp  = 0;

  logic [6:0]  exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [31:0] w_tbl[8];
  bit          l_tbl[8];
  int          n_words;

  ins_mem_writer #(.MEM_BYTES(128)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .InsMemRW(InsMemRW), .busy(busy), .done(done),
    .word_count(word_count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Model: which bytes land where, how many words get accepted, overflow.
  task automatic model_session(input logic [6:0] base, output int nacc, output bit ovf);
    int a;
    a = int'(base) & 'h7C;
    nacc = 0;
    ovf = 0;
    for (int i = 0; i < n_words; i++) begin
      for (int k = 0; k < 4; k++) begin
        exp_addr.push_back(7'((a + k) % 128));
        exp_data.push_back(8'(w_tbl[i] >> (24 - 8 * k)));
      end
      nacc++;
      a = (a + 4) % 128;
      if (l_tbl[i]) break;
      if (a == 0) begin
        ovf = 1;
        break;
      end
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 20) begin tick(); cyc++; end
    chk("done_reached", {31'd0, done}, 32'd1);
    done_exp++;
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic drive_session(input logic [6:0] base, input int nacc, input int gap,
                               input bit poke_start);
    int cyc;
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0; base_addr = 7'h00;
    for (int i = 0; i < nacc; i++) begin
      cyc = 0;
      while (!in_ready && cyc < 20) begin tick(); cyc++; end
      chk("ready_seen", {31'd0, in_ready}, 32'd1);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("ready_held_in_gap", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b1; in_data = w_tbl[i]; in_last = l_tbl[i];
      tick();
      in_valid = 1'b0; in_data = ~w_tbl[i]; in_last = 1'b0;
      cyc = 0;
      if (poke_start) begin
        start = 1'b1; base_addr = 7'h44;
        tick(); cyc++;
        start = 1'b0; base_addr = 7'h00;
      end
      if (i < nacc - 1) begin
        while (!in_ready && cyc < 20) begin tick(); cyc++; end
        chk("word_period_cycles", cyc, 4);
      end
    end
    wait_done();
  endtask

  // Per-cycle checker against the model's write queue and output invariants.
  always @(negedge CLK) begin
    if (mem_we) begin
      if (exp_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
      end else begin
        chk("write_addr", {25'd0, mem_addr}, {25'd0, exp_addr.pop_front()});
        chk("write_data", {24'd0, mem_wdata}, {24'd0, exp_data.pop_front()});
      end
      chk("busy_during_write", {31'd0, busy}, 32'd1);
    end else begin
      chk("idle_addr_zero", {25'd0, mem_addr}, 32'd0);
      chk("idle_data_zero", {24'd0, mem_wdata}, 32'd0);
    end
    chk("insmemrw_eq_busy", {31'd0, InsMemRW}, {31'd0, busy});
    if (in_ready) chk("ready_implies_busy", {31'd0, busy}, 32'd1);
    if (done) done_seen++;
  end

  initial begin
    int nacc;
    bit ovf;
    RST_n = 1'b0; start = 1'b0; base_addr = 7'h00;
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_count", {26'd0, word_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST_n = 1'b1;
    tick();

    // Single word at 0x10 with a literal byte-by-byte check.
    w_tbl[0] = 32'h8C220004; l_tbl[0] = 1; n_words = 1;
    model_session(7'h10, nacc, ovf);
    chk("model_nacc_single", nacc, 1);
    chk("model_first_byte", {24'd0, exp_data[0]}, 32'h8C);
    start = 1'b1; base_addr = 7'h10;
    tick();
    start = 1'b0;
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = w_tbl[0]; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 32'hDEADBEEF; in_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] lit;
      lit = 32'h8C220004;
      chk("lit_we", {31'd0, mem_we}, 32'd1);
      chk("lit_addr", {25'd0, mem_addr}, 32'h10 + k);
      chk("lit_data", {24'd0, mem_wdata}, {24'd0, 8'(lit >> (24 - 8 * k))});
      tick();
    end
    chk("lit_done", {31'd0, done}, 32'd1);
    done_exp++;
    chk("lit_count", {26'd0, word_count}, 32'd1);
    tick();
    chk("lit_done_clear", {31'd0, done}, 32'd0);
    chk("lit_idle", {31'd0, busy}, 32'd0);

    // Low address bits ignored.
    w_tbl[0] = 32'h11223344; l_tbl[0] = 1; n_words = 1;
    model_session(7'h13, nacc, ovf);
    chk("model_addr_align", {25'd0, exp_addr[0]}, 32'h10);
    drive_session(7'h13, nacc, 0, 0);
    chk("align_count", {26'd0, word_count}, 32'd1);

    // Three words with gaps of two idle cycles.
    w_tbl[0] = 32'hA0A1A2A3; l_tbl[0] = 0;
    w_tbl[1] = 32'hB0B1B2B3; l_tbl[1] = 0;
    w_tbl[2] = 32'hC0C1C2C3; l_tbl[2] = 1; n_words = 3;
    model_session(7'h20, nacc, ovf);
    drive_session(7'h20, nacc, 2, 0);
    chk("gap_count", {26'd0, word_count}, 32'd3);
    chk("gap_ovf", {31'd0, overflow}, 32'd0);

    // Wrap before in_last: overflow, second word refused.
    w_tbl[0] = 32'h01020304; l_tbl[0] = 0;
    w_tbl[1] = 32'h05060708; l_tbl[1] = 1; n_words = 2;
    model_session(7'h7C, nacc, ovf);
    chk("model_ovf", {31'd0, ovf}, 32'd1);
    chk("model_ovf_nacc", nacc, 1);
    drive_session(7'h7C, nacc, 0, 0);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {26'd0, word_count}, 32'd1);
    in_valid = 1'b1; in_data = w_tbl[1]; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ovf_no_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // start pulsed during WRITE is ignored.
    w_tbl[0] = 32'h55667788; l_tbl[0] = 0;
    w_tbl[1] = 32'h99AABBCC; l_tbl[1] = 1; n_words = 2;
    model_session(7'h30, nacc, ovf);
    drive_session(7'h30, nacc, 0, 1);
    chk("poke_count", {26'd0, word_count}, 32'd2);
    chk("poke_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Reset during byte index 2.
    exp_addr.push_back(7'h50); exp_data.push_back(8'hA1);
    exp_addr.push_back(7'h51); exp_data.push_back(8'hB2);
    start = 1'b1; base_addr = 7'h50;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1B2C3D4; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    tick();
    chk("rstw_addr_idx2", {25'd0, mem_addr}, 32'h52);
    RST_n = 1'b0;
    #1;
    chk("rstw_we", {31'd0, mem_we}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_insmemrw", {31'd0, InsMemRW}, 32'd0);
    chk("rstw_addr", {25'd0, mem_addr}, 32'd0);
    chk("rstw_count", {26'd0, word_count}, 32'd0);
    repeat (2) tick();
    RST_n = 1'b1;
    repeat (3) tick();
    chk("rstw_stay_idle", {31'd0, busy}, 32'd0);

    chk("queue_drained", exp_addr.size(), 0);
    chk("done_pulses", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
